// File: rtl/vmem_arbiter.sv
// Slot-based arbiter sharing the 512Kx8 video/system SRAM between screen fetch,
// CPU and DMA; one slot is one ck14 period (2 clk28 cycles), owner fixed per slot.
module vmem_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 3
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        ck14,
  output logic        fetch_allow,
  input  logic        scr_fetch,
  input  logic        scr_fetch_up,
  input  logic [14:0] scr_addr,
  input  logic [3:0]  scr_bank,
  output logic [7:0]  fetch_data,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [18:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic [7:0]  dma_rdata,
  output logic        dma_ack,
  output logic [18:0] ram_a,
  output logic [7:0]  ram_dq_out,
  output logic        ram_dq_oe,
  input  logic [7:0]  ram_dq_in,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  typedef enum logic [2:0] {IDLE, SCR, CPU_RD, CPU_WR, DMA_RD, DMA_WR} owner_t;
  typedef enum logic {LG_CPU, LG_DMA} last_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  owner_t           owner_q, owner_d;
  last_t            last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_slot, dma_slot;
  logic             cpu_elig, dma_elig;
  logic             starved;
  logic             grant_cpu, grant_dma;

  assign fetch_data = ram_dq_in;

  assign cpu_slot = (owner_q == CPU_RD) || (owner_q == CPU_WR);
  assign dma_slot = (owner_q == DMA_RD) || (owner_q == DMA_WR);
  // The requester whose slot ends on this boundary is being acked, not regranted.
  assign cpu_elig = cpu_req && !cpu_slot;
  assign dma_elig = dma_req && !dma_slot;
  assign starved  = (cnt_q >= CNT_LIMIT);

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    grant_cpu    = 1'b0;
    grant_dma    = 1'b0;
    if (ck14) begin
      if (scr_fetch && !scr_fetch_up) begin
        owner_d = SCR;
      end else if (cpu_elig && (!dma_elig || starved || last_grant_q == LG_DMA)) begin
        grant_cpu    = 1'b1;
        owner_d      = cpu_wr ? CPU_WR : CPU_RD;
        last_grant_d = LG_CPU;
      end else if (dma_elig) begin
        grant_dma    = 1'b1;
        owner_d      = dma_wr ? DMA_WR : DMA_RD;
        last_grant_d = LG_DMA;
      end else begin
        owner_d = IDLE;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!cpu_req) begin
      cnt_d = '0;
    end else if (ck14) begin
      if (grant_cpu || cpu_slot) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk28) begin
    if (rst) begin
      owner_q      <= IDLE;
      last_grant_q <= LG_DMA;
      cnt_q        <= '0;
      fetch_allow  <= 1'b1;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      fetch_allow  <= (cnt_d < CNT_LIMIT);
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      ram_a      <= '0;
      ram_dq_out <= '0;
      ram_dq_oe  <= 1'b0;
      ram_oe_n   <= 1'b1;
      ram_we_n   <= 1'b1;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      if (ck14) begin
        if (cpu_slot) begin
          cpu_ack <= 1'b1;
          if (owner_q == CPU_RD) cpu_rdata <= ram_dq_in;
        end
        if (dma_slot) begin
          dma_ack <= 1'b1;
          if (owner_q == DMA_RD) dma_rdata <= ram_dq_in;
        end
        if (owner_d == SCR) begin
          ram_a <= {scr_bank, scr_addr};
        end else if (grant_cpu) begin
          ram_a      <= cpu_addr;
          ram_dq_out <= cpu_wdata;
        end else if (grant_dma) begin
          ram_a      <= dma_addr;
          ram_dq_out <= dma_wdata;
        end
        ram_oe_n  <= !((owner_d == SCR) || (owner_d == CPU_RD) || (owner_d == DMA_RD));
        ram_dq_oe <= (owner_d == CPU_WR) || (owner_d == DMA_WR);
        ram_we_n  <= 1'b1;
      end else begin
        // Write strobe only in the second slot cycle: one cycle of address setup.
        ram_we_n <= !((owner_q == CPU_WR) || (owner_q == DMA_WR));
      end
    end
  end

endmodule
